// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss handler that fetches a whole block from pipelined memory,
// writes each word into the data array, then writes {valid, tag} for the set.
module cache_fill_fsm #(
    parameter int ADDR_W      = 16,
    parameter int OFFSET_BITS = 4,
    parameter int SET_BITS    = 6,
    localparam int WORDS      = 2 ** (OFFSET_BITS - 1),
    localparam int TAG_BITS   = ADDR_W - OFFSET_BITS - SET_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_detected,
    input  logic [ADDR_W-1:0]      miss_address,
    input  logic                   memory_data_valid,
    output logic                   fsm_busy,
    output logic                   mem_read_en,
    output logic [ADDR_W-1:0]      memory_address,
    output logic                   write_data_array,
    output logic [OFFSET_BITS-2:0] fill_word_index,
    output logic                   write_tag_array,
    output logic [SET_BITS-1:0]    fill_set,
    output logic [TAG_BITS:0]      fill_tag
);
    typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

    localparam logic [OFFSET_BITS-1:0] ALL_WORDS = OFFSET_BITS'(WORDS);
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(WORDS - 1);
    localparam logic [ADDR_W-1:0]      OFF_MASK  = ADDR_W'(2 ** OFFSET_BITS - 1);

    state_t                 state, next_state;
    logic [OFFSET_BITS-1:0] issue_cnt, recv_cnt;
    logic [ADDR_W-1:0]      base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = IDLE;
        if (state == IDLE)
            next_state = miss_detected ? FILL : IDLE;
        else if (state == FILL)
            next_state = (memory_data_valid && recv_cnt == LAST_WORD) ? TAG : FILL;
    end

    // Counters only advance in FILL; their stale values in IDLE/TAG never reach an output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (state == IDLE && miss_detected) begin
            base      <= miss_address & ~OFF_MASK;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (state == FILL) begin
            if (mem_read_en)       issue_cnt <= issue_cnt + OFFSET_BITS'(1);
            if (memory_data_valid) recv_cnt  <= recv_cnt + OFFSET_BITS'(1);
        end
    end

    always_comb begin
        fsm_busy         = state != IDLE;
        mem_read_en      = state == FILL && issue_cnt < ALL_WORDS;
        memory_address   = state == FILL ? base + ADDR_W'({issue_cnt, 1'b0}) : '0;
        write_data_array = state == FILL && memory_data_valid;
        fill_word_index  = state == FILL ? recv_cnt[OFFSET_BITS-2:0] : '0;
        write_tag_array  = state == TAG;
        fill_set         = state != IDLE ? base[OFFSET_BITS+SET_BITS-1:OFFSET_BITS] : '0;
        fill_tag         = state != IDLE ? {1'b1, base[ADDR_W-1:ADDR_W-TAG_BITS]} : '0;
    end
endmodule
